// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one memory read at a time and buffers
// returned words with their addresses in a small FIFO for the decoder.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     req_addr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic            has_room;
  logic            push;
  logic            pop;

  assign has_room   = (count < FULL);
  assign mem_req    = (state == IDLE) && has_room && !stall && !flush;
  assign mem_addr   = pc;
  assign busy       = !((state == IDLE) && has_room);
  assign inst_valid = (count != '0);
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  // Flush wins over both queue operations in the same cycle.
  assign push = (state == WAIT) && mem_ack && !flush && has_room;
  assign pop  = inst_valid && inst_ready && !flush;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_req) state_next = WAIT;
      WAIT: begin
        if (flush) state_next = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_next = IDLE;
      end
      DROP: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (mem_req) req_addr <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= req_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=2): one task per scenario,
// inputs driven 1ns after the rising edge, outputs checked 2ns after it.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .stall      (stall),
    .flush      (flush),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h0000_1000; stall = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    #3;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid got=%b want=0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got=%h want=0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc got=%h want=0", inst_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h want=00001000", mem_addr); end
    stall = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle_mem_req got=%b want=0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_fetch();
    tick();
    stall = 1'b0; pc = 32'h8002_0000;
    settle();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL single_mem_req got=%b want=1", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle got=%b want=0", busy); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h2408_0001; pc = 32'h8002_0004;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_wait got=%b want=1", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL single_no_req_wait got=%b want=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_not_yet_valid got=%b want=0", inst_valid); end
    tick();
    mem_ack = 1'b0; stall = 1'b1;
    settle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%b want=1", inst_valid); end
    checks++; if (inst !== 32'h2408_0001) begin errors++; $display("[TB] FAIL single_inst got=%h want=24080001", inst); end
    checks++; if (inst_pc !== 32'h8002_0000) begin errors++; $display("[TB] FAIL single_inst_pc got=%h want=80020000", inst_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after got=%b want=0", busy); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_popped got=%b want=0", inst_valid); end
  endtask

  task automatic test_fill();
    stall = 1'b0; pc = 32'h0000_0100;
    settle();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fill_req0 got=%b want=1", mem_req); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA000_0000; pc = 32'h0000_0104;
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fill_req1 got=%b want=1", mem_req); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA000_0001; pc = 32'h0000_0108;
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fill_busy_full got=%b want=1", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_third_req got=%b want=0", mem_req); end
    checks++; if (inst !== 32'hA000_0000) begin errors++; $display("[TB] FAIL fill_head0 got=%h want=a0000000", inst); end
    checks++; if (inst_pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL fill_head0_pc got=%h want=00000100", inst_pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_hold_req%0d got=%b want=0", i, mem_req); end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    settle();
    checks++; if (inst !== 32'hA000_0001) begin errors++; $display("[TB] FAIL fill_head1 got=%h want=a0000001", inst); end
    checks++; if (inst_pc !== 32'h0000_0104) begin errors++; $display("[TB] FAIL fill_head1_pc got=%h want=00000104", inst_pc); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fill_req_after_pop got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0108) begin errors++; $display("[TB] FAIL fill_addr2 got=%h want=00000108", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA000_0002; inst_ready = 1'b1;
    tick();
    mem_ack = 1'b0; inst_ready = 1'b0; stall = 1'b1;
    settle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got=%b want=1", inst_valid); end
    checks++; if (inst !== 32'hA000_0002) begin errors++; $display("[TB] FAIL b2b_head got=%h want=a0000002", inst); end
    checks++; if (inst_pc !== 32'h0000_0108) begin errors++; $display("[TB] FAIL b2b_head_pc got=%h want=00000108", inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_single_entry got=%b want=0", inst_valid); end
  endtask

  task automatic test_flush_late_ack();
    stall = 1'b0; pc = 32'h0000_0200;
    tick();
    flush = 1'b1; pc = 32'h0000_0300;
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_req got=%b want=0", mem_req); end
    tick();
    flush = 1'b0;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy got=%b want=1", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL drop_req got=%b want=0", mem_req); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_ack_busy got=%b want=1", busy); end
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_push got=%b want=0", inst_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL redirect_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0300) begin errors++; $display("[TB] FAIL redirect_addr got=%h want=00000300", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; stall = 1'b1;
    settle();
    checks++; if (inst !== 32'h1111_2222) begin errors++; $display("[TB] FAIL redirect_inst got=%h want=11112222", inst); end
    checks++; if (inst_pc !== 32'h0000_0300) begin errors++; $display("[TB] FAIL redirect_inst_pc got=%h want=00000300", inst_pc); end
    stall = 1'b0; flush = 1'b1;
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_req got=%b want=0", mem_req); end
    tick();
    flush = 1'b0; stall = 1'b1;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_clear got=%b want=0", inst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_state got=%b want=0", busy); end
  endtask

  task automatic test_flush_coincident();
    stall = 1'b0; pc = 32'h0000_0400;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hB000_0000; pc = 32'h0000_0404;
    tick();
    mem_ack = 1'b0;
    tick();
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hB000_0001; inst_ready = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_empty got=%b want=0", inst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL coinc_idle got=%b want=0", busy); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_no_late_push got=%b want=0", inst_valid); end
  endtask

  task automatic test_stall_in_wait();
    stall = 1'b0; pc = 32'h0000_0500;
    tick();
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hC000_0000;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_wait_busy got=%b want=1", busy); end
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_wait_push got=%b want=1", inst_valid); end
    checks++; if (inst !== 32'hC000_0000) begin errors++; $display("[TB] FAIL stall_wait_inst got=%h want=c0000000", inst); end
    checks++; if (inst_pc !== 32'h0000_0500) begin errors++; $display("[TB] FAIL stall_wait_inst_pc got=%h want=00000500", inst_pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_wait_req got=%b want=0", mem_req); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid_request();
    stall = 1'b0; pc = 32'h0000_0600;
    tick();
    stall = 1'b1;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_wait_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle got=%b want=0", busy); end
    #2;
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack_push got=%b want=0", inst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack_busy got=%b want=0", busy); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL stray_ack_inst got=%h want=0", inst); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_fill();
    test_flush_late_ack();
    test_flush_coincident();
    test_stall_in_wait();
    test_reset_mid_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction queue entries (power of two, >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 pc  input  32  current fetch address driven by the fetch unit.
REQ-005 stall  input  1  pipeline stall; no new memory request is issued while high.
REQ-006 flush  input  1  taken jump/branch this cycle; discards queued and in-flight instructions.
REQ-007 busy  output  1  to fetch unit; high when pc is not being consumed this cycle.
REQ-008 mem_req  output  1  instruction memory read request, single-cycle pulse.
REQ-009 mem_addr  output  32  read address, equal to pc while mem_req is high.
REQ-010 mem_ack  input  1  memory response strobe, one cycle, earliest the cycle after mem_req.
REQ-011 mem_rdata  input  32  instruction word, valid when mem_ack is high.
REQ-012 inst_valid  output  1  queue head holds a valid instruction.
REQ-013 inst  output  32  instruction word at queue head.
REQ-014 inst_pc  output  32  address of instruction at queue head.
REQ-015 inst_ready  input  1  decode accepts head; pop occurs when inst_valid && inst_ready.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, WAIT (one request outstanding), DROP (outstanding request to be discarded).
REQ-017 mem_req SHALL be combinational: high only when state==IDLE, count<DEPTH, stall==0, flush==0; mem_addr SHALL equal pc in all cycles.
REQ-018 busy SHALL be combinational: low exactly when state==IDLE and count<DEPTH; high otherwise.
REQ-019 On a clock edge with mem_req high the block SHALL latch pc into an internal request-address register and move IDLE->WAIT.
REQ-020 In WAIT with mem_ack high and flush low the block SHALL push {request address, mem_rdata} at the tail and move WAIT->IDLE.
REQ-021 At most one request SHALL be outstanding; a push SHALL never occur while count==DEPTH.
REQ-022 inst_valid SHALL equal (count!=0); inst and inst_pc SHALL be driven from the head entry storage (registered, no combinational path from mem_rdata).
REQ-023 Minimum latency: mem_req at cycle N, mem_ack at N+1, inst_valid high at N+2.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order (FIFO).
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 flush SHALL clear count and pointers on the same edge, overriding any push or pop that cycle.
REQ-027 flush in WAIT with mem_ack low SHALL move WAIT->DROP; flush in WAIT with mem_ack high SHALL discard the response and move WAIT->IDLE.
REQ-028 In DROP, mem_ack SHALL discard the response and move DROP->IDLE; no push occurs; busy stays high.
REQ-029 flush in IDLE SHALL suppress mem_req that cycle; state remains IDLE.
REQ-030 stall SHALL NOT affect an outstanding request, pushes, or pops; it only gates new requests.
REQ-031 mem_ack in IDLE SHALL be ignored.

Reset
REQ-032 While rst_n is low: state=IDLE, count=0, pointers=0, request-address register=0, inst_valid=0, inst=0, inst_pc=0 (queue storage cleared); hence busy=0 and mem_req follows REQ-017.
REQ-033 Reset asserted mid-request SHALL abandon the outstanding request; a later mem_ack in IDLE is ignored per REQ-031.

Verification
REQ-034 Single fetch: pc=0x8002_0000, ack one cycle later with 0x2408_0001 -> inst_valid at N+2, inst=0x2408_0001, inst_pc=0x8002_0000, busy high in WAIT cycle only.
REQ-035 Fill: inst_ready=0, three back-to-back fetches at 0x..00/04/08 with DEPTH=2 -> two entries queued, busy stays high after second push, no third mem_req until one pop.
REQ-036 Flush with late ack: flush in WAIT, mem_ack two cycles later with 0xDEAD_BEEF -> state DROP, word never appears, inst_valid=0, next mem_req uses redirected pc.
REQ-037 Flush coincident with mem_ack and a pop -> count=0, response discarded, state IDLE next cycle.
REQ-038 Stall: stall=1 in IDLE with room -> mem_req=0, busy=0; stall raised in WAIT -> ack still pushes.
REQ-039 Reset asserted in WAIT then released, stray mem_ack in IDLE -> no push, inst_valid=0.
